// File: rtl/pushbutton_debounce.sv
// Per-channel pushbutton debouncer: 2-FF synchronizer, four-state qualify FSM,
// registered level, press/release pulses and optional hold-to-auto-repeat.
module pushbutton_debounce #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 10000000,
  parameter logic [N_BTN-1:0] REPEAT_EN = N_BTN'(4'b0111)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_n,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] action_pulse
);

  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RPT_W = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;

  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] RPT_LAST   = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_RATE);

  typedef enum logic [1:0] {
    ST_RELEASED    = 2'd0,
    ST_PRESS_CHK   = 2'd1,
    ST_HELD        = 2'd2,
    ST_RELEASE_CHK = 2'd3
  } state_t;

  for (genvar i = 0; i < N_BTN; i++) begin : gen_ch
    logic [1:0]       sync_q;
    state_t           state_q;
    logic [DB_W-1:0]  db_cnt;
    logic [RPT_W-1:0] rpt_cnt;
    logic             level_q;
    logic             press_q;
    logic             release_q;
    logic             action_q;
    logic             s;

    assign s = ~sync_q[1];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync_q    <= 2'b11;
        state_q   <= ST_RELEASED;
        db_cnt    <= '0;
        rpt_cnt   <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        action_q  <= 1'b0;
      end else begin
        sync_q    <= {sync_q[0], btn_n[i]};
        press_q   <= 1'b0;
        release_q <= 1'b0;
        action_q  <= 1'b0;
        case (state_q)
          ST_RELEASED: begin
            if (s) begin
              state_q <= ST_PRESS_CHK;
              db_cnt  <= '0;
            end
          end
          ST_PRESS_CHK: begin
            if (!s) begin
              state_q <= ST_RELEASED;
            end else if (db_cnt == DB_LAST) begin
              state_q  <= ST_HELD;
              level_q  <= 1'b1;
              press_q  <= 1'b1;
              action_q <= 1'b1;
              rpt_cnt  <= '0;
            end else begin
              db_cnt <= db_cnt + 1'b1;
            end
          end
          ST_HELD: begin
            // rpt_cnt is left untouched on the way out so a rejected release
            // glitch resumes the repeat cadence where it stopped.
            if (!s) begin
              state_q <= ST_RELEASE_CHK;
              db_cnt  <= '0;
            end else if (REPEAT_EN[i]) begin
              if (rpt_cnt == RPT_LAST) begin
                action_q <= 1'b1;
                rpt_cnt  <= RPT_RELOAD;
              end else begin
                rpt_cnt <= rpt_cnt + 1'b1;
              end
            end
          end
          ST_RELEASE_CHK: begin
            if (s) begin
              state_q <= ST_HELD;
            end else if (db_cnt == DB_LAST) begin
              state_q   <= ST_RELEASED;
              level_q   <= 1'b0;
              release_q <= 1'b1;
            end else begin
              db_cnt <= db_cnt + 1'b1;
            end
          end
          default: state_q <= ST_RELEASED;
        endcase
      end
    end

    assign btn_level[i]     = level_q;
    assign press_pulse[i]   = press_q;
    assign release_pulse[i] = release_q;
    assign action_pulse[i]  = action_q;
  end

endmodule

// File: tb/tb_pushbutton_debounce.sv
// Directed bench for pushbutton_debounce with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_RATE=5, REPEAT_EN=4'b0111; expected cycles are hand-derived from the timing rules.
module tb_pushbutton_debounce;

  logic       clk;
  logic       rst;
  logic [3:0] btn_n;
  logic [3:0] btn_level;
  logic [3:0] press_pulse;
  logic [3:0] release_pulse;
  logic [3:0] action_pulse;

  int n_cmp;
  int n_err;

  pushbutton_debounce #(
    .N_BTN          (4),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_RATE    (5),
    .REPEAT_EN      (4'b0111)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_n        (btn_n),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .action_pulse (action_pulse)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e_lvl, input logic [3:0] e_pr,
                         input logic [3:0] e_rl, input logic [3:0] e_ac);
    chk({tag, ".level"},   btn_level,     e_lvl);
    chk({tag, ".press"},   press_pulse,   e_pr);
    chk({tag, ".release"}, release_pulse, e_rl);
    chk({tag, ".action"},  action_pulse,  e_ac);
  endtask

  // one rising edge, then sample 1 time unit later
  task automatic step(input string tag, input int k, input logic [3:0] e_lvl,
                      input logic [3:0] e_pr, input logic [3:0] e_rl, input logic [3:0] e_ac);
    @(posedge clk);
    #1;
    chk_all($sformatf("%s[%0d]", tag, k), e_lvl, e_pr, e_rl, e_ac);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b0;
    btn_n = 4'hF;

    // reset state
    #1;
    chk_all("reset_async", 4'b0, 4'b0, 4'b0, 4'b0);
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset_held", 4'b0, 4'b0, 4'b0, 4'b0);
    rst = 1'b1;
    for (int k = 1; k <= 3; k++) step("idle", k, 4'b0, 4'b0, 4'b0, 4'b0);

    // 1: clean press on ch0 held 30 cycles, repeats at +10 then every 5, then release
    for (int k = 1; k <= 40; k++) begin
      btn_n[0] = (k <= 30) ? 1'b0 : 1'b1;
      step("press0", k,
           {3'b0, (k >= 7 && k <= 36)},
           {3'b0, (k == 7)},
           {3'b0, (k == 37)},
           {3'b0, (k == 7 || k == 17 || k == 22 || k == 27 || k == 32)});
    end

    // 2: bounce on ch1 never qualifies
    for (int k = 1; k <= 14; k++) begin
      btn_n[1] = (k <= 3 || k == 5 || k == 6) ? 1'b0 : 1'b1;
      step("bounce1", k, 4'b0, 4'b0, 4'b0, 4'b0);
    end

    // 3: confirm held 40 cycles: single press, no repeat, release 7 edges after going high
    for (int k = 1; k <= 50; k++) begin
      btn_n[3] = (k <= 40) ? 1'b0 : 1'b1;
      step("confirm3", k,
           {(k >= 7 && k <= 46), 3'b0},
           {(k == 7), 3'b0},
           {(k == 47), 3'b0},
           {(k == 7), 3'b0});
    end

    // 4: release glitch on ch2; repeat delayed by the 3 frozen cycles
    for (int k = 1; k <= 40; k++) begin
      btn_n[2] = (k == 12 || k == 13 || k >= 31) ? 1'b1 : 1'b0;
      step("glitch2", k,
           {1'b0, (k >= 7 && k <= 36), 2'b0},
           {1'b0, (k == 7), 2'b0},
           {1'b0, (k == 37), 2'b0},
           {1'b0, (k == 7 || k == 20 || k == 25 || k == 30), 2'b0});
    end

    // 5: ch0 and ch2 pressed on the same edge
    for (int k = 1; k <= 18; k++) begin
      btn_n = (k <= 8) ? 4'b1010 : 4'b1111;
      step("dual", k,
           (k >= 7 && k <= 14) ? 4'b0101 : 4'b0000,
           (k == 7) ? 4'b0101 : 4'b0000,
           (k == 15) ? 4'b0101 : 4'b0000,
           (k == 7) ? 4'b0101 : 4'b0000);
    end

    // 6: reset while ch0 HELD, button stays down, must re-qualify
    btn_n[0] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step("pre_rst0", k, {3'b0, (k >= 7)}, {3'b0, (k == 7)}, 4'b0, {3'b0, (k == 7)});
    end
    #2;
    rst = 1'b0;
    #1;
    chk_all("rst_mid_held", 4'b0, 4'b0, 4'b0, 4'b0);
    @(posedge clk);
    #1;
    chk_all("rst_mid_edge", 4'b0, 4'b0, 4'b0, 4'b0);
    #2;
    rst = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      btn_n[0] = (k <= 10) ? 1'b0 : 1'b1;
      step("post_rst0", k,
           {3'b0, (k >= 7 && k <= 16)},
           {3'b0, (k == 7)},
           {3'b0, (k == 17)},
           {3'b0, (k == 7)});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pushbutton_debounce.md
Name: pushbutton_debounce

Overview:
- Per-channel debouncer and press-event generator for the board pushbuttons (3 digit buttons + confirm).
- Sits directly upstream of the digit/confirm synchronizer stages and feeds them clean levels and single-cycle pulses.
- Optional hold-to-auto-repeat on selected channels lets a held digit button keep stepping.
- Raw buttons are asynchronous and active-low. The block contains its own 2-FF synchronizers.

Parameters:
- N_BTN, 4, number of button channels; bit 3 is confirm, bits 2:0 are digits.
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed to accept a press or release (20 ms at 50 MHz); must be ≥ 2.
- REPEAT_DELAY, 25000000, HELD cycles before the first auto-repeat.
- REPEAT_RATE, 10000000, cycles between subsequent auto-repeats; must satisfy 1 ≤ REPEAT_RATE ≤ REPEAT_DELAY.
- REPEAT_EN, 4'b0111, per-channel auto-repeat enable mask.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- btn_n  in  N_BTN  raw pushbuttons; 0 = pressed.
- btn_level  out  N_BTN  debounced state; 1 = pressed.
- press_pulse  out  N_BTN  one-cycle pulse on an accepted press.
- release_pulse  out  N_BTN  one-cycle pulse on an accepted release.
- action_pulse  out  N_BTN  press_pulse OR auto-repeat pulse.

Behaviour:
- All outputs are registered.
- Reset (rst=0, async):
  - Synchronizer FFs load 1 (released).
  - All channel FSMs go to RELEASED.
  - Counters load 0.
  - All outputs are 0.
- Deassertion is taken as already synchronized upstream.
- Per channel i:
  - 2-FF synchronizer on btn_n[i].
  - s = inverted second-stage output (1 = pressed).
- Counters:
  - db_cnt, width clog2(DEBOUNCE_CYCLES).
  - rpt_cnt, width clog2(REPEAT_DELAY).
- FSM, evaluated each rising edge:
  - RELEASED:
    - s=1 → PRESS_CHK, db_cnt←0.
  - PRESS_CHK:
    - s=0 → RELEASED (bounce rejected, no pulse).
    - s=1 and db_cnt=DEBOUNCE_CYCLES-1 → HELD; btn_level←1, press_pulse←1, action_pulse←1, rpt_cnt←0.
    - Otherwise db_cnt++.
  - HELD:
    - s=0 → RELEASE_CHK, db_cnt←0; rpt_cnt frozen.
    - Otherwise, if REPEAT_EN[i]:
      - rpt_cnt=REPEAT_DELAY-1 → action_pulse←1, rpt_cnt←REPEAT_DELAY-REPEAT_RATE.
      - else rpt_cnt++.
  - RELEASE_CHK:
    - s=1 → HELD (glitch rejected; no new press_pulse; rpt_cnt resumes from its frozen value).
    - s=0 and db_cnt=DEBOUNCE_CYCLES-1 → RELEASED; btn_level←0, release_pulse←1.
    - Otherwise db_cnt++.
- Pulses are high exactly one cycle; they are cleared the cycle after they are set.
- Latency: press_pulse rises after the (DEBOUNCE_CYCLES+3)th rising edge, counted from the first edge sampling btn_n[i]=0 with btn_n held low. Release is symmetric.
- Auto-repeat timing: first repeat comes REPEAT_DELAY cycles after press_pulse, then every REPEAT_RATE cycles while held.
- Channels are fully independent. Simultaneous presses on several channels produce pulses in the same cycle.
- btn_level stays 1 throughout RELEASE_CHK.
- Reset mid-debounce or while HELD:
  - Immediate return to the reset state.
  - No release_pulse is emitted.
  - A button still held after reset must re-qualify through PRESS_CHK and then produces a fresh press_pulse.
- Counters never wrap. db_cnt is bounded by DEBOUNCE_CYCLES-1, rpt_cnt by REPEAT_DELAY-1.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=5, REPEAT_EN=4'b0111):
1. Reset, then clean press of btn_n[0] held 30 cycles:
   - press_pulse[0] and action_pulse[0] high for 1 cycle, 7 edges after the first low sample.
   - btn_level[0]=1.
   - action_pulse[0] repeats 10 cycles after the press pulse, then every 5 cycles.
2. Bounce: btn_n[1] low 3 cycles, high 1, low 2, high:
   - No pulses.
   - btn_level[1] stays 0.
3. Confirm btn_n[3] held 40 cycles then released:
   - Exactly one press_pulse[3] and one action_pulse[3] (no repeat, mask bit 3 = 0).
   - release_pulse[3] 1 cycle, 7 edges after the first high sample.
   - btn_level[3] falls with it.
4. Release glitch: while HELD, btn_n[2] high for 2 cycles then low again:
   - No release_pulse and no new press_pulse.
   - btn_level[2] stays 1.
   - Repeat cadence resumes from the frozen count.
5. btn_n[0] and btn_n[2] pressed on the same edge:
   - press_pulse=4'b0101 in a single cycle.
6. Assert rst while channel 0 is HELD with the button still down, then deassert:
   - Outputs 0 immediately, no release_pulse.
   - After deassert, a fresh press_pulse[0] at DEBOUNCE_CYCLES+3 edges.
